// File: rtl/aes_inv_key_expansion_if.sv
// Handshake bundle between a key source, the inverse key schedule and the decrypt datapath.
// Carries the round-10 key load channel and the round-key output stream.
// master = key source / key consumer side (the bench), slave = aes_inv_key_expansion.
interface aes_inv_key_expansion_if;
  logic         i_valid;
  logic         i_ready;
  logic [127:0] last_key;
  logic         o_valid;
  logic         o_ready;
  logic [127:0] o_key;
  logic [3:0]   o_round;
  logic         o_last;

  modport master (
    output i_valid, last_key, o_ready,
    input  i_ready, o_valid, o_key, o_round, o_last
  );

  modport slave (
    input  i_valid, last_key, o_ready,
    output i_ready, o_valid, o_key, o_round, o_last
  );
endinterface

// File: rtl/aes_inv_key_expansion.sv
// AES-128 inverse key schedule: load round-10 key, stream round keys 10..0 (one per handshake).
// Latency: key accepted at cycle N -> round 10 at N+1, round 0 at N+11 with o_ready high, idle at N+12.
// Backpressure: o_key/o_round/o_last hold while o_valid && !o_ready; i_valid ignored while busy.
// Optional macro AES_EQINV_KEY_EN: rounds 9..1 emitted through InvMixColumns (equivalent inverse cipher keys).

module rot_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  assign o_word = {i_word[23:0], i_word[31:24]};
endmodule

module sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]], SBOX[i_word[15:8]], SBOX[i_word[7:0]]};
endmodule

module aes_inv_key_expansion #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input logic clk,
  input logic reset,
  aes_inv_key_expansion_if.slave kx
);
  if (NR != 10 || KEY_W != 128) begin : g_cfg_err
    $error("aes_inv_key_expansion supports only AES-128 (NR=10, KEY_W=128)");
  end

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]   r_state;
  logic [127:0] r_raw;
  logic [3:0]   r_round;
  logic         r_valid;

  logic [31:0]  w_a, w_b, w_c, w_d;
  logic [31:0]  w_a_n, w_b_n, w_c_n, w_d_n;
  logic [31:0]  w_rot, w_sub;
  logic [7:0]   w_rcon;
  logic [127:0] w_prev;
  logic         w_hs, w_load, w_step;

  assign {w_a, w_b, w_c, w_d} = r_raw;
  assign w_d_n = w_d ^ w_c;
  assign w_c_n = w_c ^ w_b;
  assign w_b_n = w_b ^ w_a;

  rot_word u_rot (.i_word(w_d_n), .o_word(w_rot));
  sub_word u_sub (.i_word(w_rot), .o_word(w_sub));

  // Round constant for the round currently held; 0 and 11..15 never feed an emitted key
  always_comb begin
    w_rcon = 8'h00;
    case (r_round)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_a_n  = w_a ^ w_sub ^ {w_rcon, 24'h000000};
  assign w_prev = {w_a_n, w_b_n, w_c_n, w_d_n};

  assign w_hs   = r_valid & kx.o_ready;
  assign w_load = (r_state == ST_IDLE) & kx.i_valid;
  assign w_step = (r_state == ST_EMIT) & w_hs & (r_round != 4'd0);

  // Schedule walk: load round 10, step back one round per accepted key, retire after round 0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_raw   <= '0;
      r_round <= 4'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (kx.i_valid) begin
            r_raw   <= kx.last_key;
            r_round <= 4'd10;
            r_valid <= 1'b1;
            r_state <= ST_EMIT;
          end
        end
        default: begin
          if (w_hs) begin
            if (r_round != 4'd0) begin
              r_raw   <= w_prev;
              r_round <= r_round - 4'd1;
            end else begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign kx.i_ready = (r_state == ST_IDLE);
  assign kx.o_valid = r_valid;
  assign kx.o_round = r_round;
  assign kx.o_last  = r_valid & (r_round == 4'd0);

`ifdef AES_EQINV_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 0x09 / 0x0b / 0x0d / 0x0e selected by k (0..3)
  function automatic logic [7:0] gm(input logic [7:0] b, input int k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    case (k)
      0:       return x8 ^ b;
      1:       return x8 ^ x2 ^ b;
      2:       return x8 ^ x4 ^ b;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] w);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = w;
    return {gm(s0,3) ^ gm(s1,1) ^ gm(s2,2) ^ gm(s3,0),
            gm(s0,0) ^ gm(s1,3) ^ gm(s2,1) ^ gm(s3,2),
            gm(s0,2) ^ gm(s1,0) ^ gm(s2,3) ^ gm(s3,1),
            gm(s0,1) ^ gm(s1,2) ^ gm(s2,0) ^ gm(s3,3)};
  endfunction

  logic [127:0] r_okey;
  logic [127:0] w_okey_next;

  // Next emitted round is r_round-1; only rounds 9..1 get the column transform
  always_comb begin
    w_okey_next = w_prev;
    if (r_round >= 4'd2 && r_round <= 4'd10)
      w_okey_next = {imc_col(w_a_n), imc_col(w_b_n), imc_col(w_c_n), imc_col(w_d_n)};
  end

  // Registered output copy so the transformed key appears with the same latency as the raw one
  always_ff @(posedge clk) begin
    if (reset)       r_okey <= '0;
    else if (w_load) r_okey <= kx.last_key;
    else if (w_step) r_okey <= w_okey_next;
  end

  assign kx.o_key = r_okey;
`else
  assign kx.o_key = r_raw;
`endif
endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Scoreboard bench for aes_inv_key_expansion: model pushes expected round keys, monitor pops on handshake.
// Reference schedule is the textbook word recurrence run backwards with a GF(2^8)-derived S-box.
// Covers reset state, latency, known vectors, back-pressure, busy ignore, mid-run reset, random keys.
module tb_aes_inv_key_expansion;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_inv_key_expansion_if kx();
  aes_inv_key_expansion #(.NR(10), .KEY_W(128)) dut (.clk(clk), .reset(reset), .kx(kx));

  typedef struct packed { logic [127:0] key; logic [3:0] round; } exp_t;
  exp_t         sb[$];
  logic [127:0] exp_rk [11];
  logic [127:0] cap_key [11];
  logic [7:0]   sbox [256];
  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] K1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [31:0] imc(input logic [31:0] w);
    logic [7:0] s [4];
    logic [7:0] r [4];
    logic [7:0] m [4];
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    {s[0], s[1], s[2], s[3]} = w;
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'h00;
      for (int j = 0; j < 4; j++) r[i] ^= gmul(m[(j - i + 4) % 4], s[j]);
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  // Reference: w[i] = w[i-4] ^ temp solved for w[i-4], walking i from 43 down to 4
  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc [11];
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int j = 2; j <= 10; j++) rc[j] = gmul(rc[j-1], 8'h02);
    {w[40], w[41], w[42], w[43]} = k;
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/4], 24'h0};
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
`ifdef AES_EQINV_KEY_EN
      if (r >= 1 && r <= 9)
        exp_rk[r] = {imc(w[4*r]), imc(w[4*r+1]), imc(w[4*r+2]), imc(w[4*r+3])};
`endif
    end
  endtask

  // Monitor: every presented-and-accepted key must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && kx.o_valid && kx.o_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_key", {124'h0, kx.o_round}, 128'hffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_round", {124'h0, kx.o_round}, {124'h0, e.round});
        chk("sb_key", kx.o_key, e.key);
        chk("sb_last", {127'h0, kx.o_last}, {127'h0, (e.round == 4'd0)});
        cap_key[kx.o_round] = kx.o_key;
      end
    end
  end

  bit rnd_bp = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rnd_bp) kx.o_ready = ($urandom_range(0, 3) != 0);
  end

  // Caller sits at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic load(input logic [127:0] k);
    int t = 0;
    while (!kx.i_ready && t < 100) begin @(posedge clk); #1; t++; end
    chk("load_ready", {127'h0, kx.i_ready}, 128'h1);
    model(k);
    for (int r = 10; r >= 0; r--) sb.push_back('{key: exp_rk[r], round: 4'(r)});
    kx.last_key = k;
    kx.i_valid  = 1'b1;
    @(posedge clk); #1;
    kx.i_valid  = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((kx.o_valid || sb.size() != 0) && t < 400) begin @(posedge clk); #1; t++; end
    chk("drain_sb_empty", 128'(sb.size()), 128'h0);
    chk("drain_idle", {127'h0, kx.i_ready}, 128'h1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t;
    logic [127:0] rk;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
    end
    kx.i_valid = 1'b0; kx.last_key = '0; kx.o_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_i_ready", {127'h0, kx.i_ready}, 128'h1);
    chk("rst_o_valid", {127'h0, kx.o_valid}, 128'h0);
    chk("rst_o_last",  {127'h0, kx.o_last},  128'h0);
    chk("rst_o_round", {124'h0, kx.o_round}, 128'h0);
    chk("rst_o_key",   kx.o_key, 128'h0);

    // Nominal walk with latency count
    kx.o_ready = 1'b1;
    load(K1);
    chk("lat_o_valid", {127'h0, kx.o_valid}, 128'h1);
    chk("lat_round10", {124'h0, kx.o_round}, 128'd10);
    t = 0;
    while (!kx.i_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("lat_idle_cycles", 128'(t), 128'd11);
    wait_done();
    chk("k1_round10", cap_key[10], K1);
`ifndef AES_EQINV_KEY_EN
    chk("k1_round9", cap_key[9], 128'hac7766f319fadc2128d12941575c006e);
`endif
    chk("k1_round0", cap_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Second known key
    load(K2);
    wait_done();
    chk("k2_round10", cap_key[10], K2);
`ifdef AES_EQINV_KEY_EN
    chk("k2_round9", cap_key[9], 128'h13aa29be9c8faff6f770f58000f7bf03);
`else
    chk("k2_round9", cap_key[9], 128'h549932d1f08557681093ed9cbe2c974e);
`endif
    chk("k2_round0", cap_key[0], 128'h000102030405060708090a0b0c0d0e0f);

    // Back-pressure held at round 7
    load({$urandom, $urandom, $urandom, $urandom});
    rk = exp_rk[7];
    t = 0;
    while (!(kx.o_valid && kx.o_round == 4'd7) && t < 50) begin @(posedge clk); #1; t++; end
    kx.o_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_round", {124'h0, kx.o_round}, 128'd7);
      chk("bp_hold_key", kx.o_key, rk);
      @(posedge clk); #1;
    end
    kx.o_ready = 1'b1;
    wait_done();

    // i_valid during EMIT is ignored; no auto-restart afterwards
    load(K1);
    repeat (3) @(posedge clk);
    #1;
    kx.last_key = K2;
    kx.i_valid  = 1'b1;
    chk("busy_i_ready", {127'h0, kx.i_ready}, 128'h0);
    @(posedge clk); #1;
    kx.i_valid = 1'b0;
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    chk("no_restart_o_valid", {127'h0, kx.o_valid}, 128'h0);

    // Reset while emitting round 5
    load(K2);
    t = 0;
    while (!(kx.o_valid && kx.o_round == 4'd5) && t < 50) begin @(posedge clk); #1; t++; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_o_valid", {127'h0, kx.o_valid}, 128'h0);
    chk("midrst_i_ready", {127'h0, kx.i_ready}, 128'h1);
    sb.delete();
    load(K1);
    chk("midrst_restart10", {124'h0, kx.o_round}, 128'd10);
    wait_done();

    // Random keys under random back-pressure
    rnd_bp = 1'b1;
    for (int n = 0; n < 20; n++) begin
      load({$urandom, $urandom, $urandom, $urandom});
      wait_done();
    end
    rnd_bp = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/aes_inv_key_expansion.md
Name: aes_inv_key_expansion

Overview:
- Reverse-direction AES-128 key schedule for the decrypt path.
- Loads the final (round-10) round key and walks the schedule backwards one round per handshake.
- Streams round keys 10 down to 0 to the AES decryption datapath over a valid/ready interface.
- Removes the need to store the full 1408-bit forward schedule on the decrypt side.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported, and any other value is a elaboration error.
- KEY_W, 128, round key width in bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- i_valid  input  1  last_key valid
- i_ready  output  1  block idle and able to accept a key
- last_key  input  128  round-10 round key w[40..43]; w[40] = bits [127:96]
- o_valid  output  1  o_key/o_round valid
- o_ready  input  1  downstream accepts current round key
- o_key  output  128  round key for o_round; same word order as last_key
- o_round  output  4  round index of o_key, 10 down to 0
- o_last  output  1  high with o_valid when o_round == 0

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: i_ready=1, o_valid=0, o_last=0, o_round=0, o_key=0, state=IDLE.
- Reset mid-operation aborts the sequence immediately. No further keys are emitted. The next cycle is IDLE with i_ready=1.
- States:
  - IDLE: i_ready=1, o_valid=0. When i_valid=1, register last_key into o_key, set o_round=10 and o_valid=1, then go to EMIT.
  - EMIT: i_ready=0. On each o_valid&&o_ready handshake:
    - If o_round>0: o_key <= prev(o_key, o_round) and o_round <= o_round-1.
    - If o_round==0: o_valid <= 0, go to IDLE.
- i_valid while in EMIT is ignored. The key is not captured and not queued.
- Latency:
  - Key accepted at cycle N gives round 10 on o_key at cycle N+1.
  - With o_ready held high, rounds 10..0 appear on 11 consecutive cycles (N+1..N+11).
  - i_ready returns high at N+12.
- Back-pressure: while o_valid=1 and o_ready=0, o_key, o_round and o_last hold stable.
- o_last = o_valid && (o_round==0), decoded combinationally from registers.
- prev() is combinational. With current key words a,b,c,d (a = [127:96]) at round r:
  - d' = d ^ c
  - c' = c ^ b
  - b' = b ^ a
  - a' = a ^ SubWord(RotWord(d')) ^ {Rcon[r],24'h0}
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- SubWord and RotWord are instances of the existing sub_word and rot_word modules.
- Rcon is a case on o_round. Rounds 0 and 11..15 select 00; these values are never used.
- A single round of logic sits between registers; there is no multi-cycle path.

Optional Feature:
- Macro: AES_EQINV_KEY_EN.
- When defined, o_key for rounds 9..1 is InvMixColumns applied column-wise to the raw round key. Rounds 10 and 0 are output unmodified. This gives direct keys for the FIPS-197 equivalent inverse cipher.
  - The internal schedule register always holds raw keys; the transform is applied only on the output path.
  - The output path is registered so that latency is unchanged.
- When undefined, o_key is always the raw round key and no InvMixColumns logic is synthesized.

Test Plan:
- Nominal walk: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 with o_ready=1. Expect, one per cycle:
  - o_round=10, o_key=d014f9a8c9ee2589e13f0cc8b6630ca6
  - o_round=9, o_key=ac7766f319fadc2128d12941575c006e
  - …
  - o_round=0, o_key=2b7e151628aed2a6abf7158809cf4f3c, with o_last=1
  - i_ready=1 on the following cycle.
- Second key: last_key=13111d7fe3944a17f307a78b4d2b30c5. Expect:
  - round 9 = 549932d1f08557681093ed9cbe2c974e
  - round 0 = 000102030405060708090a0b0c0d0e0f
- Back-pressure: drop o_ready for 3 cycles while o_round=7. Expect o_key/o_round unchanged for all 3 cycles, then resume at round 6 with no skip or duplicate.
- Busy ignore: pulse i_valid with a different key during EMIT. Expect i_ready=0 and the sequence unaffected. After o_last, the block idles and does not auto-restart.
- Reset mid-operation: assert reset at o_round=5. Next cycle expect o_valid=0 and i_ready=1. A fresh load then restarts at round 10.
- With AES_EQINV_KEY_EN and the second key:
  - round 10 = 13111d7fe3944a17f307a78b4d2b30c5 (unmodified)
  - round 9 = 13aa29be9c8faff6f770f58000f7bf03
  - round 0 = 000102030405060708090a0b0c0d0e0f (unmodified)
